// File: rtl/pac_pkg.sv
// Shared types and defaults for the Pac-Man direction controller.
// Direction encodings, FSM state type and the default request lifetime.
package pac_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  localparam int PEND_TICKS_DEF = 8;

endpackage

// File: rtl/pac_edge_pri.sv
// Button press detector: per-button rising edge plus fixed priority
// UP > DOWN > LEFT > RIGHT, yielding at most one press per cycle.
module pac_edge_pri
  import pac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lvl_i,        // [0]=up [1]=down [2]=left [3]=right
  output logic       press_valid_o,
  output dir_t       press_dir_o
);

  logic [3:0] prev_q;
  logic [3:0] rise;

  // Previous levels reset high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 4'b1111;
    end else begin
      prev_q <= lvl_i;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rise
      assign rise[gi] = lvl_i[gi] & ~prev_q[gi];
    end
  endgenerate

  always_comb begin
    press_valid_o = |rise;
    press_dir_o   = DIR_RIGHT;
    if (rise[0]) begin
      press_dir_o = DIR_UP;
    end else if (rise[1]) begin
      press_dir_o = DIR_DOWN;
    end else if (rise[2]) begin
      press_dir_o = DIR_LEFT;
    end
  end

endmodule

// File: rtl/pac_dir_ctrl.sv
// Pac-Man heading controller: buffers a turn request with a limited lifetime
// and resolves it against maze walls on each move tick.
module pac_dir_ctrl
  import pac_pkg::*;
#(
  parameter int PEND_TICKS = PEND_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_tick,
  input  logic       pend_blocked,
  input  logic       cur_blocked,
  output logic [1:0] cur_dir,
  output logic [1:0] pending_dir,
  output logic       pending_valid,
  output logic       moving,
  output logic       step,
  output logic       turn
);

  localparam int LW = $clog2(PEND_TICKS + 1);

  state_t        state_q, state_d;
  dir_t          cur_dir_q, cur_dir_d;
  dir_t          pend_dir_q, pend_dir_d;
  logic          pend_valid_q, pend_valid_d;
  logic [LW-1:0] life_q, life_d;
  logic          step_q, step_d;
  logic          turn_q, turn_d;

  logic          press_valid;
  dir_t          press_dir;
  logic          consume;

  pac_edge_pri u_edge_pri (
    .clk           (clk),
    .rst           (rst),
    .lvl_i         ({btn_right, btn_left, btn_down, btn_up}),
    .press_valid_o (press_valid),
    .press_dir_o   (press_dir)
  );

  assign consume = move_tick & pend_valid_q & ~pend_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_LEFT;
      pend_dir_q   <= DIR_LEFT;
      pend_valid_q <= 1'b0;
      life_q       <= '0;
      step_q       <= 1'b0;
      turn_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      life_q       <= life_d;
      step_q       <= step_d;
      turn_q       <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (consume) begin
      state_d = ST_MOVING;
    end else if (move_tick && state_q == ST_MOVING && cur_blocked) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    cur_dir_d    = cur_dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    life_d       = life_q;
    step_d       = 1'b0;
    turn_d       = 1'b0;
    if (consume) begin
      cur_dir_d    = pend_dir_q;
      pend_valid_d = 1'b0;
      life_d       = '0;
      step_d       = 1'b1;
      turn_d       = 1'b1;
    end else if (move_tick) begin
      // A blocked request ages; the tick that sees life==1 retires it.
      if (pend_valid_q) begin
        if (life_q <= LW'(1)) begin
          pend_valid_d = 1'b0;
        end
        if (life_q != '0) begin
          life_d = life_q - LW'(1);
        end
      end
      if (state_q == ST_MOVING && !cur_blocked) begin
        step_d = 1'b1;
      end
    end
    // A fresh press lands after the tick decision and wins over any clear.
    if (press_valid) begin
      pend_dir_d   = press_dir;
      pend_valid_d = 1'b1;
      life_d       = LW'(PEND_TICKS);
    end
  end

  always_comb begin
    cur_dir       = cur_dir_q;
    pending_dir   = pend_dir_q;
    pending_valid = pend_valid_q;
    moving        = (state_q == ST_MOVING);
    step          = step_q;
    turn          = turn_q;
  end

endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Directed vector bench for pac_dir_ctrl: table of one-cycle vectors plus
// hand-written hold/reset/coincident-press sequences.
module tb_pac_dir_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] btn;   // [0]=up [1]=down [2]=left [3]=right
    logic       tick;
    logic       pb;
    logic       cb;
    logic [1:0] cd;
    logic [1:0] pd;
    logic       pv;
    logic       mv;
    logic       st;
    logic       tn;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       move_tick = 1'b0;
  logic       pend_blocked = 1'b0;
  logic       cur_blocked = 1'b0;
  logic [1:0] cur_dir;
  logic [1:0] pending_dir;
  logic       pending_valid;
  logic       moving;
  logic       step;
  logic       turn;

  int vectors = 0;
  int miscompares = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pac_dir_ctrl #(.PEND_TICKS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up        (btn[0]),
    .btn_down      (btn[1]),
    .btn_left      (btn[2]),
    .btn_right     (btn[3]),
    .move_tick     (move_tick),
    .pend_blocked  (pend_blocked),
    .cur_blocked   (cur_blocked),
    .cur_dir       (cur_dir),
    .pending_dir   (pending_dir),
    .pending_valid (pending_valid),
    .moving        (moving),
    .step          (step),
    .turn          (turn)
  );

  function automatic vec_t mk(input logic r, input logic [3:0] b, input logic t,
                              input logic p, input logic c, input logic [1:0] ecd,
                              input logic [1:0] epd, input logic epv, input logic emv,
                              input logic est, input logic etn);
    vec_t v;
    v.rst = r; v.btn = b; v.tick = t; v.pb = p; v.cb = c;
    v.cd = ecd; v.pd = epd; v.pv = epv; v.mv = emv; v.st = est; v.tn = etn;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rst          = v.rst;
    btn          = v.btn;
    move_tick    = v.tick;
    pend_blocked = v.pb;
    cur_blocked  = v.cb;
    @(posedge clk);
    #1;
    vectors++;
    if (cur_dir !== v.cd || pending_dir !== v.pd || pending_valid !== v.pv ||
        moving !== v.mv || step !== v.st || turn !== v.tn) begin
      miscompares++;
      $display("FAIL %s vec %0d: got cd=%0d pd=%0d pv=%0d mv=%0d st=%0d tn=%0d, want cd=%0d pd=%0d pv=%0d mv=%0d st=%0d tn=%0d",
               tag, vectors, cur_dir, pending_dir, pending_valid, moving, step, turn,
               v.cd, v.pd, v.pv, v.mv, v.st, v.tn);
    end else begin
      $display("vec %0d %s: cd=%0d pd=%0d pv=%0d mv=%0d st=%0d tn=%0d",
               vectors, tag, cur_dir, pending_dir, pending_valid, moving, step, turn);
    end
  endtask

  initial begin
    //            rst btn     tk pb cb  cd pd pv mv st tn
    vq.push_back(mk(1, 4'b0000, 0, 0, 0, 2, 2, 0, 0, 0, 0)); // reset state
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 2, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0001, 0, 0, 0, 2, 0, 1, 0, 0, 0)); // press up
    vq.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0, 1, 1, 1)); // consume -> MOVING UP
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 4'b1000, 0, 0, 0, 0, 3, 1, 1, 0, 0)); // press right
    vq.push_back(mk(0, 4'b0000, 1, 0, 0, 3, 3, 0, 1, 1, 1)); // turn RIGHT
    vq.push_back(mk(0, 4'b0010, 0, 0, 0, 3, 1, 1, 1, 0, 0)); // press down
    for (int i = 0; i < 8; i++) // blocked request ages for 8 ticks
      vq.push_back(mk(0, 4'b0000, 1, 1, 0, 3, 1, (i < 7) ? 1'b1 : 1'b0, 1, 1, 0));
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 3, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 4'b0000, 1, 1, 0, 3, 1, 0, 1, 1, 0)); // plain step
    vq.push_back(mk(0, 4'b0100, 0, 0, 0, 3, 2, 1, 1, 0, 0)); // press left
    vq.push_back(mk(0, 4'b0000, 1, 0, 0, 2, 2, 0, 1, 1, 1)); // turn LEFT
    vq.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 2, 0, 0, 0, 0)); // wall -> IDLE
    vq.push_back(mk(0, 4'b0000, 0, 0, 0, 2, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0000, 1, 0, 1, 2, 2, 0, 0, 0, 0)); // idle tick, no step
    vq.push_back(mk(0, 4'b0101, 0, 0, 0, 2, 0, 1, 0, 0, 0)); // left+up -> UP wins

    @(posedge clk);
    #1;
    foreach (vq[i]) apply(vq[i], "table");

    // Hold left+up 50 cycles; request ages out and is never re-armed.
    for (int i = 0; i < 50; i++) begin
      if (i < 10)
        apply(mk(0, 4'b0101, 1, 1, 1, 2, 0, (i < 7) ? 1'b1 : 1'b0, 0, 0, 0), "hold");
      else
        apply(mk(0, 4'b0101, 0, 0, 0, 2, 0, 0, 0, 0, 0), "hold");
    end
    apply(mk(0, 4'b0000, 0, 0, 0, 2, 0, 0, 0, 0, 0), "release");

    // Right held through reset produces no press until re-pressed.
    apply(mk(1, 4'b1000, 1, 0, 0, 2, 2, 0, 0, 0, 0), "rst_held");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 4'b1000, 0, 0, 0, 2, 2, 0, 0, 0, 0), "held");
    apply(mk(0, 4'b0000, 0, 0, 0, 2, 2, 0, 0, 0, 0), "release");
    apply(mk(0, 4'b1000, 0, 0, 0, 2, 3, 1, 0, 0, 0), "repress");

    // Press coincident with consumable tick: old UP consumed, DOWN buffered.
    apply(mk(0, 4'b0000, 0, 0, 0, 2, 3, 1, 0, 0, 0), "release");
    apply(mk(0, 4'b0001, 0, 0, 0, 2, 0, 1, 0, 0, 0), "press_up");
    apply(mk(0, 4'b0011, 1, 0, 0, 0, 1, 1, 1, 1, 1), "coincide");
    apply(mk(0, 4'b0011, 0, 0, 0, 0, 1, 1, 1, 0, 0), "after");

    // Mid-move reset discards the pending request.
    apply(mk(1, 4'b0000, 1, 0, 0, 2, 2, 0, 0, 0, 0), "mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pac_dir_ctrl.md
PAC_DIR_CTRL -- requirements
Module: pac_dir_ctrl

Interface
REQ-001 Parameter PEND_TICKS, default 8: number of move ticks a buffered turn request survives unconsumed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced, synchronized button levels, 1 = pressed.
REQ-005 move_tick  input  1  one-cycle pulse from game timer; Pac-Man may advance one tile.
REQ-006 pend_blocked  input  1  maze lookup, combinational from pending_dir; 1 = wall in the pending direction.
REQ-007 cur_blocked  input  1  maze lookup, combinational from cur_dir; 1 = wall in the current direction.
REQ-008 cur_dir  output  2  current heading, registered.
REQ-009 pending_dir  output  2  buffered requested heading, registered.
REQ-010 pending_valid  output  1  pending_dir holds a live request.
REQ-011 moving  output  1  1 in state MOVING.
REQ-012 step  output  1  one-cycle pulse, position advances one tile.
REQ-013 turn  output  1  one-cycle pulse, cur_dir loaded from pending_dir.

Function
REQ-014 Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-015 Press detection: per button, rise = level AND NOT previous-cycle level; one press per rising edge regardless of hold time.
REQ-016 Simultaneous rises: priority UP > DOWN > LEFT > RIGHT; only the winner is recorded.
REQ-017 Any rise loads pending_dir, sets pending_valid, reloads lifetime counter to PEND_TICKS; an existing request is overwritten.
REQ-018 States: IDLE, MOVING. Decisions are made only in a cycle with move_tick = 1.
REQ-019 IDLE + tick + pending_valid + !pend_blocked: cur_dir <= pending_dir, clear pending, -> MOVING, pulse turn and step.
REQ-020 MOVING + tick + pending_valid + !pend_blocked: cur_dir <= pending_dir, clear pending, stay MOVING, pulse turn and step; applies to reversals and to same-direction requests.
REQ-021 MOVING + tick, no consumable request, !cur_blocked: stay MOVING, pulse step.
REQ-022 MOVING + tick, no consumable request, cur_blocked: -> IDLE, no step.
REQ-023 Tick with pending_valid and pend_blocked: request retained, lifetime decremented; counter at 1 on that tick clears pending_valid.
REQ-024 step and turn are registered: asserted exactly the cycle after the deciding move_tick, width one cycle.
REQ-025 Press coincident with move_tick: decision uses the old pending; the new press is then written, overriding any clear in that cycle.
REQ-026 Lifetime counter width is ceil(log2(PEND_TICKS+1)); no wrap, saturates at 0.
REQ-027 No move_tick: cur_dir, state and lifetime are held; presses still update pending.

Reset
REQ-028 On rst: state IDLE, cur_dir = LEFT, pending_dir = LEFT, pending_valid = 0, moving = 0, step = 0, turn = 0, lifetime = 0.
REQ-029 On rst, previous-level registers are loaded to 1, so a button held through reset generates no press until released and re-pressed.
REQ-030 rst overrides move_tick and presses in the same cycle; a mid-move reset discards the pending request.

Structure
REQ-031 Shared package pac_pkg holds the direction type and its four encodings, the state type, and PEND_TICKS default.
REQ-032 One sub-module, pac_edge_pri: 4-bit rise detect plus priority encode, outputs press valid + 2-bit direction; the FSM and counter stay in pac_dir_ctrl.

Verification
REQ-033 Reset, pulse btn_up, then move_tick with pend_blocked=0 -> next cycle turn=1, step=1, cur_dir=UP, moving=1, pending_valid=0.
REQ-034 MOVING RIGHT, pulse btn_down, pend_blocked=1 for 8 ticks, cur_blocked=0 -> 8 step pulses, cur_dir stays RIGHT, pending_valid drops after the 8th tick.
REQ-035 MOVING LEFT, no request, tick with cur_blocked=1 -> moving=0, no step; a later tick with cur_blocked=1 also yields no step.
REQ-036 btn_left and btn_up rise in the same cycle -> pending_dir=UP; hold both 50 cycles -> no further press.
REQ-037 btn_right held across rst -> no pending after reset; release and re-press -> pending_dir=RIGHT.
REQ-038 pending=UP; btn_down rises in the same cycle as a consumable tick -> cur_dir=UP, turn pulses, then pending_dir=DOWN, pending_valid=1.
